// File: rtl/world_clock_ctrl_pkg.sv
// rtl/world_clock_ctrl_pkg.sv - city table constants and LCD sequencer state encoding
package world_clock_ctrl_pkg;

    localparam int         NUM_CITIES_DEF = 7;
    localparam logic [2:0] SEOUL_IDX      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } lcd_state_t;

    // String literals put the first character in the top byte; the LCD side
    // wants byte 0 = first character, so reverse the byte order once here.
    function automatic logic [47:0] name6(input logic [47:0] s);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = s[8*(5-i) +: 8];
        end
        return r;
    endfunction

    localparam logic [47:0] CITY_NAME [0:6] = '{
        name6("London"), name6("Paris "), name6("Moscow"), name6("Dubai "),
        name6("Seoul "), name6("Tokyo "), name6("Sydney")
    };

    localparam logic signed [4:0] CITY_DIFF [0:6] = '{
        -5'sd9, -5'sd8, -5'sd6, -5'sd5, 5'sd0, 5'sd0, 5'sd2
    };

endpackage

// File: rtl/world_clock_ctrl_if.sv
// rtl/world_clock_ctrl_if.sv - character write handshake towards the LCD writer
interface world_clock_ctrl_if;
    logic       lcd_req;
    logic [6:0] lcd_addr;
    logic [7:0] lcd_data;
    logic       lcd_ack;

    modport master (output lcd_req, output lcd_addr, output lcd_data, input lcd_ack);
    modport slave  (input lcd_req, input lcd_addr, input lcd_data, output lcd_ack);
endinterface

// File: rtl/world_clock_ctrl_btn_debounce.sv
// rtl/world_clock_ctrl_btn_debounce.sv - button synchronizer, debounce filter and press pulse
module btn_debounce #(
    parameter int CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

    logic          sync0;
    logic          sync1;
    logic          stable;
    logic [CW-1:0] cnt;

    // Accept a new level only after it has held for CYC cycles; pulse on accepted rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(CYC - 1)) begin
                stable <= sync1;
                cnt    <= '0;
                press  <= sync1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/world_clock_ctrl.sv
// rtl/world_clock_ctrl.sv - city selection, auto-rotate and LCD name write sequencer
module world_clock_ctrl
    import world_clock_ctrl_pkg::*;
#(
    parameter int         NUM_CITIES   = NUM_CITIES_DEF,
    parameter int         DEBOUNCE_CYC = 16,
    parameter int         AUTO_SEC     = 5,
    parameter logic [6:0] LCD_BASE     = 7'h40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_1hz,
    input  logic                      btn_next,
    input  logic                      btn_mode,
    world_clock_ctrl_if.master        lcd,
    output logic [2:0]                city_idx,
    output logic signed [4:0]         city_diff,
    output logic [47:0]               city_name,
    output logic                      auto_mode,
    output logic                      busy
);
    localparam int DW = (AUTO_SEC > 1) ? $clog2(AUTO_SEC) : 1;

    logic          next_p;
    logic          mode_p;
    logic          auto_adv;
    logic          adv;
    logic          adv_d;
    logic          refresh_pending;
    logic [DW-1:0] dwell;

    lcd_state_t    state;
    lcd_state_t    state_nxt;
    logic [2:0]    k;
    logic [47:0]   shadow;

    btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (next_p)
    );

    btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .press (mode_p)
    );

    // A simultaneous button press and auto advance collapse into one step.
    assign auto_adv = auto_mode && tick_1hz && (dwell == DW'(AUTO_SEC - 1));
    assign adv      = next_p || auto_adv;

    // City index, auto mode and dwell seconds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            city_idx  <= SEOUL_IDX;
            auto_mode <= 1'b0;
            dwell     <= '0;
            adv_d     <= 1'b0;
        end else begin
            adv_d <= adv;
            if (adv) begin
                city_idx <= (city_idx == 3'(NUM_CITIES - 1)) ? 3'd0 : city_idx + 3'd1;
            end
            if (mode_p) begin
                auto_mode <= !auto_mode;
            end
            if (mode_p || adv) begin
                dwell <= '0;
            end else if (auto_mode && tick_1hz) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Registered table lookup, one cycle behind city_idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            city_diff <= 5'sd0;
            city_name <= CITY_NAME[SEOUL_IDX];
        end else begin
            city_diff <= CITY_DIFF[city_idx];
            city_name <= CITY_NAME[city_idx];
        end
    end

    // Sequencer state plus refresh flag, name shadow and char position.
    // The refresh flag is raised together with the table update so IDLE latches the new name.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            k               <= 3'd0;
            shadow          <= '0;
            refresh_pending <= 1'b1;
        end else begin
            state <= state_nxt;
            if (adv_d) begin
                refresh_pending <= 1'b1;
            end else if (state == ST_IDLE && refresh_pending) begin
                refresh_pending <= 1'b0;
            end
            if (state == ST_IDLE && refresh_pending) begin
                shadow <= city_name;
                k      <= 3'd0;
            end else if (state == ST_GAP && state_nxt == ST_SEND) begin
                k <= k + 3'd1;
            end
        end
    end

    // Next state: a pending refresh abandons the current name at the next gap.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (refresh_pending) state_nxt = ST_SEND;
            ST_SEND: if (lcd.lcd_ack) state_nxt = ST_GAP;
            ST_GAP: begin
                if (refresh_pending)  state_nxt = ST_IDLE;
                else if (k == 3'd5)   state_nxt = ST_IDLE;
                else                  state_nxt = ST_SEND;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so the request drops with an asynchronous reset.
    always_comb begin
        lcd.lcd_req  = (state == ST_SEND);
        lcd.lcd_addr = LCD_BASE + {4'b0000, k};
        lcd.lcd_data = (state == ST_SEND) ? shadow[{k, 3'b000} +: 8] : 8'h00;
        busy         = (state != ST_IDLE);
    end
endmodule

// File: tb/tb_world_clock_ctrl.sv
// tb/tb_world_clock_ctrl.sv - randomized self-checking bench for world_clock_ctrl
module tb_world_clock_ctrl;
    localparam int AUTO_SEC = 5;
    localparam int NCITY    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_1hz;
    logic              btn_next;
    logic              btn_mode;
    logic [2:0]        city_idx;
    logic signed [4:0] city_diff;
    logic [47:0]       city_name;
    logic              auto_mode;
    logic              busy;

    world_clock_ctrl_if lcd_bus ();

    world_clock_ctrl #(
        .NUM_CITIES   (NCITY),
        .DEBOUNCE_CYC (16),
        .AUTO_SEC     (AUTO_SEC),
        .LCD_BASE     (7'h40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .btn_next  (btn_next),
        .btn_mode  (btn_mode),
        .lcd       (lcd_bus),
        .city_idx  (city_idx),
        .city_diff (city_diff),
        .city_name (city_name),
        .auto_mode (auto_mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    string names [NCITY] = '{"London", "Paris ", "Moscow", "Dubai ", "Seoul ", "Tokyo ", "Sydney"};
    int    diffs [NCITY] = '{-9, -8, -6, -5, 0, 0, 2};

    int m_idx;
    bit m_auto;
    int m_dwell;

    int n_checks = 0;
    int n_fail   = 0;

    int         ack_dly    = 0;
    int         stable_bad = 0;
    logic [6:0] log_addr [$];
    logic [7:0] log_data [$];

    logic [6:0] r_a0;
    logic [7:0] r_d0;
    bit         r_abort;
    int         r_d;

    int cal_lat;
    int w;
    int oldc;
    int newc;
    logic [2:0] prev_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // LCD writer model: acks each request after ack_dly cycles and records the write.
    initial begin
        lcd_bus.lcd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && lcd_bus.lcd_req) begin
                r_a0    = lcd_bus.lcd_addr;
                r_d0    = lcd_bus.lcd_data;
                r_abort = 1'b0;
                r_d     = ack_dly;
                for (int i = 0; i < r_d; i++) begin
                    @(negedge clk);
                    if (!rst) r_abort = 1'b1;
                    else if (!r_abort && (!lcd_bus.lcd_req || lcd_bus.lcd_addr != r_a0 ||
                                          lcd_bus.lcd_data != r_d0)) stable_bad++;
                end
                if (!r_abort && rst && lcd_bus.lcd_req) begin
                    log_addr.push_back(lcd_bus.lcd_addr);
                    log_data.push_back(lcd_bus.lcd_data);
                    lcd_bus.lcd_ack = 1'b1;
                    @(negedge clk);
                    lcd_bus.lcd_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_city(input string tag);
        logic [47:0] en;
        logic [4:0]  ed;
        for (int i = 0; i < 6; i++) en[8*i +: 8] = names[m_idx][i];
        ed = diffs[m_idx][4:0];
        check({tag, "/idx"},  64'(city_idx), 64'(m_idx));
        check({tag, "/diff"}, {59'b0, city_diff}, {59'b0, ed});
        check({tag, "/name"}, {16'b0, city_name}, {16'b0, en});
        check({tag, "/auto"}, {63'b0, auto_mode}, {63'b0, m_auto});
    endtask

    task automatic check_log(input string tag, input int start, input int n, input int city);
        logic [63:0] ga, ea, gd, ed;
        ga = '0; ea = '0; gd = '0; ed = '0;
        for (int i = 0; i < n; i++) begin
            if (start + i < log_addr.size()) begin
                ga = (ga << 7) | 64'(log_addr[start + i]);
                gd = (gd << 8) | 64'(log_data[start + i]);
            end else begin
                ga = ga << 7;
                gd = gd << 8;
            end
            ea = (ea << 7) | 64'(32'h40 + i);
            ed = (ed << 8) | 64'(names[city][i]);
        end
        check({tag, "/lcd_addr"}, ga, ea);
        check({tag, "/lcd_data"}, gd, ed);
    endtask

    task automatic expect_lcd(input string tag, input bit adv);
        int waited;
        waited = 0;
        if (adv) begin
            while (log_data.size() < 6 && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
        end
        repeat (30) @(negedge clk);
        check({tag, "/lcd_count"}, 64'(log_data.size()), adv ? 64'd6 : 64'd0);
        if (adv) check_log(tag, 0, 6, m_idx);
    endtask

    task automatic drive_btn(input bit which, input bit v);
        if (which) btn_mode = v;
        else       btn_next = v;
    endtask

    task automatic press(input bit which, input int hold, input bit bouncy);
        if (bouncy) begin
            for (int i = 0; i < 3; i++) begin
                drive_btn(which, 1'b1);
                repeat ($urandom_range(1, 5)) @(negedge clk);
                drive_btn(which, 1'b0);
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        drive_btn(which, 1'b1);
        repeat (hold) @(negedge clk);
        if (bouncy) begin
            for (int i = 0; i < 3; i++) begin
                drive_btn(which, 1'b0);
                repeat ($urandom_range(1, 5)) @(negedge clk);
                drive_btn(which, 1'b1);
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        drive_btn(which, 1'b0);
        repeat (30) @(negedge clk);
    endtask

    task automatic op_next(input bit bouncy);
        clear_log();
        press(1'b0, $urandom_range(30, 60), bouncy);
        m_idx   = (m_idx + 1) % NCITY;
        m_dwell = 0;
        check_city("next");
        expect_lcd("next", 1'b1);
    endtask

    task automatic op_mode();
        clear_log();
        press(1'b1, $urandom_range(30, 50), 1'b1);
        m_auto  = !m_auto;
        m_dwell = 0;
        check_city("mode");
        expect_lcd("mode", 1'b0);
    endtask

    task automatic op_tick();
        bit adv;
        clear_log();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        adv = 1'b0;
        if (m_auto) begin
            if (m_dwell == AUTO_SEC - 1) begin
                adv     = 1'b1;
                m_idx   = (m_idx + 1) % NCITY;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
        end
        repeat (3) @(negedge clk);
        check_city("tick");
        expect_lcd("tick", adv);
    endtask

    initial begin
        rst      = 1'b0;
        tick_1hz = 1'b0;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        m_idx    = 4;
        m_auto   = 1'b0;
        m_dwell  = 0;
        repeat (3) @(negedge clk);

        check_city("reset");
        check("reset/lcd_req",  {63'b0, lcd_bus.lcd_req}, 64'd0);
        check("reset/busy",     {63'b0, busy}, 64'd0);
        check("reset/lcd_addr", {57'b0, lcd_bus.lcd_addr}, 64'h40);
        check("reset/lcd_data", {56'b0, lcd_bus.lcd_data}, 64'd0);

        clear_log();
        rst = 1'b1;
        expect_lcd("boot", 1'b1);
        check_city("boot");

        // Clean press: measure button-to-index latency, then index-to-request latency.
        clear_log();
        prev_idx = city_idx;
        btn_next = 1'b1;
        cal_lat  = 0;
        while (city_idx == prev_idx && cal_lat < 200) begin
            @(negedge clk);
            cal_lat++;
        end
        m_idx = (m_idx + 1) % NCITY;
        check("cal/idx", 64'(city_idx), 64'(m_idx));
        w = 0;
        while (!lcd_bus.lcd_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cal/adv_to_req", 64'(w), 64'd2);
        repeat (40) @(negedge clk);
        btn_next = 1'b0;
        repeat (30) @(negedge clk);
        check_city("cal");
        expect_lcd("cal", 1'b1);

        // Bouncy held presses through the table wrap.
        for (int i = 0; i < 9; i++) op_next(1'b1);

        // Auto rotation.
        op_mode();
        for (int i = 0; i < AUTO_SEC; i++) op_tick();
        for (int i = 0; i < AUTO_SEC - 1; i++) op_tick();
        clear_log();
        btn_next = 1'b1;
        repeat (cal_lat - 1) @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        repeat (30) @(negedge clk);
        m_idx   = (m_idx + 1) % NCITY;
        m_dwell = 0;
        check_city("next_on_tick");
        expect_lcd("next_on_tick", 1'b1);
        for (int i = 0; i < AUTO_SEC; i++) op_tick();
        op_mode();
        op_tick();
        op_tick();

        // City change while a character waits for its ack.
        clear_log();
        oldc       = (m_idx + 1) % NCITY;
        newc       = (m_idx + 2) % NCITY;
        stable_bad = 0;
        btn_next   = 1'b1;
        w = 0;
        while (log_data.size() < 2 && w < 400) begin
            @(negedge clk);
            w++;
        end
        ack_dly  = 80;
        btn_next = 1'b0;
        repeat (25) @(negedge clk);
        btn_next = 1'b1;
        w = 0;
        while (city_idx != 3'(newc) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("mid/idx", 64'(city_idx), 64'(newc));
        ack_dly = 0;
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        w = 0;
        while (log_data.size() < 9 && w < 600) begin
            @(negedge clk);
            w++;
        end
        repeat (30) @(negedge clk);
        check("mid/lcd_count", 64'(log_data.size()), 64'd9);
        check_log("mid/old", 0, 3, oldc);
        check_log("mid/new", 3, 6, newc);
        check("mid/stable", 64'(stable_bad), 64'd0);
        m_idx   = newc;
        m_dwell = 0;
        check_city("mid");

        // Reset while a request is outstanding.
        op_mode();
        clear_log();
        ack_dly  = 20;
        btn_next = 1'b1;
        w = 0;
        while (!lcd_bus.lcd_req && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("rst/req_before", {63'b0, lcd_bus.lcd_req}, 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        m_idx   = 4;
        m_auto  = 1'b0;
        m_dwell = 0;
        check("rst/lcd_req", {63'b0, lcd_bus.lcd_req}, 64'd0);
        check_city("rst");
        btn_next = 1'b0;
        repeat (5) @(negedge clk);
        clear_log();
        ack_dly = 0;
        rst     = 1'b1;
        expect_lcd("rst_boot", 1'b1);

        // Random mix of operations against the model.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       op_next(1'($urandom_range(0, 1)));
                1, 2:    op_tick();
                default: op_mode();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
